// File: rtl/servo_command_pwm.sv
// Decodes collector command words into two servo positions and drives one
// PWM output per servo. Pulse widths only change at the frame wrap.
module servo_command_pwm #(
  parameter int PERIOD_CYCLES    = 1000000,
  parameter int MIN_PULSE_CYCLES = 50000,
  parameter int STEP_CYCLES      = 196,
  parameter int PARK_POS         = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] mbed_data,
  input  logic        ready,
  output logic        pwm_0,
  output logic        pwm_1,
  output logic [7:0]  position_0,
  output logic [7:0]  position_1,
  output logic        mode_running,
  output logic        cmd_strobe
);

  localparam int              CW          = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0]   LAST_COUNT  = CW'(PERIOD_CYCLES - 1);
  localparam logic [7:0]      PARK        = 8'(PARK_POS);
  localparam logic [CW-1:0]   PARK_WIDTH  = CW'(MIN_PULSE_CYCLES + PARK_POS * STEP_CYCLES);

  logic [2:0]    r_sync;
  logic          r_strobe;
  logic          r_mode;
  logic [7:0]    r_pos_0;
  logic [7:0]    r_pos_1;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_active_0;
  logic [CW-1:0] r_active_1;
  logic          r_pwm_0;
  logic          r_pwm_1;

  logic          w_accept;
  logic [7:0]    w_eff_0;
  logic [7:0]    w_eff_1;
  logic [CW-1:0] w_target_0;
  logic [CW-1:0] w_target_1;
  logic          w_wrap;

  // Flops reset high so a ready already asserted out of reset gives no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], ready};
    end
  end

  assign w_accept = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe <= 1'b0;
      r_mode   <= 1'b0;
      r_pos_0  <= PARK;
      r_pos_1  <= PARK;
    end else begin
      r_strobe <= 1'b0;
      if (w_accept && mbed_data[10]) begin
        r_strobe <= 1'b1;
        r_mode   <= mbed_data[9];
        if (mbed_data[9]) begin
          if (mbed_data[8]) r_pos_1 <= mbed_data[7:0];
          else              r_pos_0 <= mbed_data[7:0];
        end
      end
    end
  end

  // Maintenance parks both servos without losing the running positions.
  assign w_eff_0    = r_mode ? r_pos_0 : PARK;
  assign w_eff_1    = r_mode ? r_pos_1 : PARK;
  assign w_target_0 = CW'(MIN_PULSE_CYCLES + 32'(w_eff_0) * STEP_CYCLES);
  assign w_target_1 = CW'(MIN_PULSE_CYCLES + 32'(w_eff_1) * STEP_CYCLES);
  assign w_wrap     = (r_cnt == LAST_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_active_0 <= PARK_WIDTH;
      r_active_1 <= PARK_WIDTH;
      r_pwm_0    <= 1'b0;
      r_pwm_1    <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_cnt      <= '0;
        r_active_0 <= w_target_0;
        r_active_1 <= w_target_1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_pwm_0 <= (r_cnt < r_active_0);
      r_pwm_1 <= (r_cnt < r_active_1);
    end
  end

  assign pwm_0        = r_pwm_0;
  assign pwm_1        = r_pwm_1;
  assign position_0   = r_pos_0;
  assign position_1   = r_pos_1;
  assign mode_running = r_mode;
  assign cmd_strobe   = r_strobe;

endmodule
